// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions: machine word width and fetch FSM state encodings.
// Imported by the instruction fetch unit, the program counter and the decoder
// so that all of them agree on word size and state values.
package instr_fetch_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit.
// Samples the PC, issues a read to instruction memory, waits for the
// acknowledge, hands the word to the decoder and pulses the PC enable once
// per delivered instruction. A flush (branch redirect) discards any fetch
// that is in flight or being held for the decoder.
//
// Ports:
//   I_clk        system clock, rising edge
//   I_reset      synchronous, active-high reset
//   I_pc         current PC, sampled as the fetch address
//   O_pc_enable  one-cycle pulse that advances the PC
//   I_flush      branch redirect; PC is written on the same edge
//   O_mem_addr   instruction memory read address
//   O_mem_req    read request, held until acknowledged
//   I_mem_ack    memory acknowledge, I_mem_data valid in the same cycle
//   I_mem_data   instruction word from memory
//   O_instr      instruction to the decoder
//   O_valid      O_instr is valid
//   I_ready      decoder accepts O_instr when O_valid && I_ready
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic [15:0] I_pc,
  output logic        O_pc_enable,
  input  logic        I_flush,
  output logic [15:0] O_mem_addr,
  output logic        O_mem_req,
  input  logic        I_mem_ack,
  input  logic [15:0] I_mem_data,
  output logic [15:0] O_instr,
  output logic        O_valid,
  input  logic        I_ready
);

  fetch_state_e state_q, state_d;
  logic         drop_q, drop_d;
  logic         mem_req_q, mem_req_d;
  word_t        mem_addr_q, mem_addr_d;
  word_t        instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         pc_en_q, pc_en_d;

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q    <= S_REQ;
      drop_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      pc_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      pc_en_q    <= pc_en_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    // The PC enable is a single-cycle pulse, so it falls back every cycle.
    pc_en_d    = 1'b0;

    case (state_q)
      S_REQ: begin
        // On a flush the PC is being rewritten this edge; wait one cycle so
        // the redirected value is what gets sampled.
        if (!I_flush) begin
          mem_addr_d = I_pc;
          mem_req_d  = 1'b1;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (I_mem_ack) begin
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          if (I_flush || drop_q) begin
            // Stale fetch: throw the word away and refetch from the new PC.
            state_d = S_REQ;
          end else begin
            instr_d = I_mem_data;
            valid_d = 1'b1;
            pc_en_d = 1'b1;
            state_d = S_HOLD;
          end
        end else if (I_flush) begin
          // The memory still owes us a response; keep requesting and
          // remember to discard it.
          drop_d = 1'b1;
        end
      end

      S_HOLD: begin
        // Flush has priority: a coincident ready is not an accept.
        if (I_flush || I_ready) begin
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  assign O_pc_enable = pc_en_q;
  assign O_mem_addr  = mem_addr_q;
  assign O_mem_req   = mem_req_q;
  assign O_instr     = instr_q;
  assign O_valid     = valid_q;

endmodule
